bfloat_mult_pipe: RTL

Parametrised, pipelined floating-point multiplier for the BFloat16 datapath and the successor to the single-register bfloat multiplier. It adds a generic exponent/mantissa width, selectable rounding (truncate or round-to-nearest-even), full special-value handling, exception flags, and a valid/ready stream handshake with backpressure. It sits between the operand fetch stage and the MAC accumulator; default parameters give IEEE-style bf16 (1/8/7).

---
 rtl/bfloat_mult_pipe.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/bfloat_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bfloat_mult_pipe
// Description : Three-stage pipelined floating-point multiplier. Defaults give
//               bf16 (1/8/7). It supports truncate or round-to-nearest-even
//               rounding, full special-value handling and exception flags,
//               and a valid/ready stream with backpressure.
//               Stage 1 : classify operands, result sign, exponent sum,
//                         mantissa product
//               Stage 2 : normalise, round, exponent adjust
//               Stage 3 : range check, special select, pack into c/flags
// Ports       : clk       - clock, rising edge
//               rst_n     - asynchronous active-low reset
//               in_valid  - operand pair valid
//               in_ready  - pair accepted when in_valid && in_ready
//               a, b      - operands {sign, exp, man}
//               out_valid - result valid
//               out_ready - downstream accepts result
//               c         - product
//               flags     - {nv, of, uf, nx}, aligned with c
// Revision    : 1.0 - initial release
// ============================================================================
module bfloat_mult_pipe #(
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 7,
    parameter int ROUND_RNE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] c,
    output logic [3:0]           flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX = (1 << EXP_W) - 1;
    // Exponent arithmetic width: two extra bits so sums and negative
    // intermediate exponents never wrap.
    localparam int EP   = EXP_W + 2;
    localparam int PW   = 2 * (MAN_W + 1);

    // Result class carried down the pipe
    localparam logic [1:0] K_NORM = 2'd0;
    localparam logic [1:0] K_NAN  = 2'd1;
    localparam logic [1:0] K_INF  = 2'd2;
    localparam logic [1:0] K_ZERO = 2'd3;

    // ------------------------------------------------------------------
    // Handshake: every stage advances together unless the output is stuck
    // ------------------------------------------------------------------
    logic w_advance;
    logic r_out_valid;

    assign w_advance = !(r_out_valid && !out_ready);
    assign in_ready  = w_advance;

    // ------------------------------------------------------------------
    // Stage 1 combinational: classify, sign, exponent sum, product
    // ------------------------------------------------------------------
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_ma, w_mb;
    logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [1:0]       w_kind1;
    logic             w_nv1;
    logic [EP-1:0]    w_esum;
    logic [PW-1:0]    w_prod;

    assign w_ea = a[W-2 -: EXP_W];
    assign w_eb = b[W-2 -: EXP_W];
    assign w_ma = a[MAN_W-1:0];
    assign w_mb = b[MAN_W-1:0];

    // exp==0 covers subnormals, which are flushed to zero without nx
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == {EXP_W{1'b1}}) && (w_ma == '0);
    assign w_b_inf  = (w_eb == {EXP_W{1'b1}}) && (w_mb == '0);
    assign w_a_nan  = (w_ea == {EXP_W{1'b1}}) && (w_ma != '0);
    assign w_b_nan  = (w_eb == {EXP_W{1'b1}}) && (w_mb != '0);

    always_comb begin
        w_kind1 = K_NORM;
        w_nv1   = 1'b0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_kind1 = K_NAN;
            // Invalid only for Inf*0 or a signalling NaN (mantissa MSB clear)
            w_nv1   = (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero) ||
                      (w_a_nan && !w_ma[MAN_W-1]) || (w_b_nan && !w_mb[MAN_W-1]);
        end else if (w_a_inf || w_b_inf) begin
            w_kind1 = K_INF;
        end else if (w_a_zero || w_b_zero) begin
            w_kind1 = K_ZERO;
        end
    end

    assign w_esum = {2'b00, w_ea} + {2'b00, w_eb} - EP'(BIAS);
    assign w_prod = PW'({1'b1, w_ma}) * PW'({1'b1, w_mb});

    logic             r1_valid, r1_sign, r1_nv;
    logic [1:0]       r1_kind;
    logic [EP-1:0]    r1_exp;
    logic [PW-1:0]    r1_prod;

    // ------------------------------------------------------------------
    // Stage 2 combinational: normalise and round
    // ------------------------------------------------------------------
    logic [PW-2:0]    w_norm;
    logic [MAN_W-1:0] w_frac;
    logic             w_g, w_s, w_inc;
    logic [MAN_W:0]   w_rsum;
    logic [EP-1:0]    w_exp2;

    // Product lies in [1,4): align so the leading one drops off the top
    assign w_norm = r1_prod[PW-1] ? r1_prod[PW-2:0] : {r1_prod[PW-3:0], 1'b0};
    assign w_frac = w_norm[PW-2 -: MAN_W];
    assign w_g    = w_norm[PW-2-MAN_W];
    assign w_s    = |w_norm[PW-3-MAN_W:0];
    assign w_inc  = (ROUND_RNE != 0) && w_g && (w_s || w_frac[0]);
    assign w_rsum = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_inc};
    // A rounding carry-out leaves the fraction at zero and bumps the exponent
    assign w_exp2 = r1_exp + EP'(r1_prod[PW-1]) + EP'(w_rsum[MAN_W]);

    logic             r2_valid, r2_sign, r2_nv, r2_nx;
    logic [1:0]       r2_kind;
    logic [EP-1:0]    r2_exp;
    logic [MAN_W-1:0] r2_man;

    // ------------------------------------------------------------------
    // Stage 3 combinational: range check and special select
    // ------------------------------------------------------------------
    logic         w_of, w_uf;
    logic [W-1:0] w_c3;
    logic [3:0]   w_f3;

    // r2_exp is two's complement: MSB set means negative
    assign w_of = !r2_exp[EP-1] && (r2_exp >= EP'(EMAX));
    assign w_uf = r2_exp[EP-1] || (r2_exp == '0);

    always_comb begin
        w_c3 = {r2_sign, r2_exp[EXP_W-1:0], r2_man};
        w_f3 = {3'b000, r2_nx};
        case (r2_kind)
            K_NAN: begin
                w_c3 = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                w_f3 = {r2_nv, 3'b000};
            end
            K_INF: begin
                w_c3 = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                w_f3 = 4'b0000;
            end
            K_ZERO: begin
                w_c3 = {r2_sign, {(W-1){1'b0}}};
                w_f3 = 4'b0000;
            end
            default: begin
                if (w_of) begin
                    w_c3 = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    w_f3 = 4'b0101;
                end else if (w_uf) begin
                    w_c3 = {r2_sign, {(W-1){1'b0}}};
                    w_f3 = 4'b0011;
                end
            end
        endcase
    end

    logic [W-1:0] r_c;
    logic [3:0]   r_flags;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid    <= 1'b0;
            r1_sign     <= 1'b0;
            r1_nv       <= 1'b0;
            r1_kind     <= K_NORM;
            r1_exp      <= '0;
            r1_prod     <= '0;
            r2_valid    <= 1'b0;
            r2_sign     <= 1'b0;
            r2_nv       <= 1'b0;
            r2_nx       <= 1'b0;
            r2_kind     <= K_NORM;
            r2_exp      <= '0;
            r2_man      <= '0;
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_flags     <= '0;
        end else if (w_advance) begin
            r1_valid <= in_valid;
            if (in_valid) begin
                r1_sign <= a[W-1] ^ b[W-1];
                r1_nv   <= w_nv1;
                r1_kind <= w_kind1;
                r1_exp  <= w_esum;
                r1_prod <= w_prod;
            end

            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_sign <= r1_sign;
                r2_nv   <= r1_nv;
                r2_nx   <= w_g | w_s;
                r2_kind <= r1_kind;
                r2_exp  <= w_exp2;
                r2_man  <= w_rsum[MAN_W-1:0];
            end

            r_out_valid <= r2_valid;
            if (r2_valid) begin
                r_c     <= w_c3;
                r_flags <= w_f3;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign c         = r_c;
    assign flags     = r_flags;

endmodule
`default_nettype wire
